// File: rtl/triangle_cull_stage.sv
// Triangle setup/reject stage: latches a triangle, computes twice its signed area and
// drops degenerate, off-screen and behind-eye triangles. Optional macro: BACKFACE_CULL_EN.
module triangle_cull_stage #(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 320,
  parameter int SCREEN_H     = 240,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [WIDTH-1:0]        in_ax,
  input  logic signed [WIDTH-1:0]        in_ay,
  input  logic signed [WIDTH-1:0]        in_az,
  input  logic signed [WIDTH-1:0]        in_bx,
  input  logic signed [WIDTH-1:0]        in_by,
  input  logic signed [WIDTH-1:0]        in_bz,
  input  logic signed [WIDTH-1:0]        in_cx,
  input  logic signed [WIDTH-1:0]        in_cy,
  input  logic signed [WIDTH-1:0]        in_cz,
  input  logic        [COLOUR_WIDTH-1:0] in_colour,
  input  logic                           in_draw_en,
  output logic                           in_draw_done,
  output logic signed [WIDTH-1:0]        ax,
  output logic signed [WIDTH-1:0]        ay,
  output logic signed [WIDTH-1:0]        az,
  output logic signed [WIDTH-1:0]        bx,
  output logic signed [WIDTH-1:0]        by,
  output logic signed [WIDTH-1:0]        bz,
  output logic signed [WIDTH-1:0]        cx,
  output logic signed [WIDTH-1:0]        cy,
  output logic signed [WIDTH-1:0]        cz,
  output logic        [COLOUR_WIDTH-1:0] colour,
  output logic                           draw_en,
  input  logic                           draw_done,
  output logic        [COUNT_WIDTH-1:0]  accepted_cnt,
  output logic        [COUNT_WIDTH-1:0]  rejected_cnt
);

  localparam int EW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 2;
  localparam int AW = 2 * WIDTH + 3;
  localparam logic signed [WIDTH-1:0] X_LIMIT = WIDTH'(SCREEN_W);
  localparam logic signed [WIDTH-1:0] Y_LIMIT = WIDTH'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_CROSS,
    S_DECIDE,
    S_REJECT,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state_reg, state_next;

  logic signed [WIDTH-1:0] vx_in  [3];
  logic signed [WIDTH-1:0] vy_in  [3];
  logic signed [WIDTH-1:0] vz_in  [3];
  logic signed [WIDTH-1:0] vx_reg [3];
  logic signed [WIDTH-1:0] vy_reg [3];
  logic signed [WIDTH-1:0] vz_reg [3];
  logic [COLOUR_WIDTH-1:0] colour_reg;
  logic                    load;

  assign vx_in[0] = in_ax;
  assign vy_in[0] = in_ay;
  assign vz_in[0] = in_az;
  assign vx_in[1] = in_bx;
  assign vy_in[1] = in_by;
  assign vz_in[1] = in_bz;
  assign vx_in[2] = in_cx;
  assign vy_in[2] = in_cy;
  assign vz_in[2] = in_cz;

  assign load = (state_reg == S_IDLE) && in_draw_en;

  // The latched vertices double as the outputs, so they stay put through WAIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= '0;
        vy_reg[i] <= '0;
        vz_reg[i] <= '0;
      end
      colour_reg <= '0;
    end else if (load) begin
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= vx_in[i];
        vy_reg[i] <= vy_in[i];
        vz_reg[i] <= vz_in[i];
      end
      colour_reg <= in_colour;
    end
  end

  assign ax     = vx_reg[0];
  assign ay     = vy_reg[0];
  assign az     = vz_reg[0];
  assign bx     = vx_reg[1];
  assign by     = vy_reg[1];
  assign bz     = vz_reg[1];
  assign cx     = vx_reg[2];
  assign cy     = vy_reg[2];
  assign cz     = vz_reg[2];
  assign colour = colour_reg;

  function automatic logic signed [EW-1:0] ext_e(input logic signed [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  function automatic logic signed [PW-1:0] ext_p(input logic signed [EW-1:0] v);
    return {{(PW - EW){v[EW-1]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] ext_a(input logic signed [PW-1:0] v);
    return {v[PW-1], v};
  endfunction

  logic signed [EW-1:0] e1x_reg, e1y_reg, e2x_reg, e2y_reg;
  logic signed [PW-1:0] p0_reg, p1_reg;
  logic signed [AW-1:0] area2;

  always_ff @(posedge clock) begin
    if (state_reg == S_EDGE) begin
      e1x_reg <= ext_e(vx_reg[1]) - ext_e(vx_reg[0]);
      e1y_reg <= ext_e(vy_reg[1]) - ext_e(vy_reg[0]);
      e2x_reg <= ext_e(vx_reg[2]) - ext_e(vx_reg[0]);
      e2y_reg <= ext_e(vy_reg[2]) - ext_e(vy_reg[0]);
    end
  end

  // Operands are widened to the product width first, so the products are exact.
  always_ff @(posedge clock) begin
    if (state_reg == S_CROSS) begin
      p0_reg <= ext_p(e1x_reg) * ext_p(e2y_reg);
      p1_reg <= ext_p(e1y_reg) * ext_p(e2x_reg);
    end
  end

  // One extra bit keeps the difference of two extreme products from overflowing.
  assign area2 = ext_a(p0_reg) - ext_a(p1_reg);

  logic [2:0] x_low, x_high, y_low, y_high, z_low;

  for (genvar gi = 0; gi < 3; gi++) begin : g_vtx
    assign x_low[gi]  = vx_reg[gi][WIDTH-1];
    assign x_high[gi] = vx_reg[gi] >= X_LIMIT;
    assign y_low[gi]  = vy_reg[gi][WIDTH-1];
    assign y_high[gi] = vy_reg[gi] >= Y_LIMIT;
    assign z_low[gi]  = vz_reg[gi][WIDTH-1];
  end

  logic backface;
  logic reject_now;

`ifdef BACKFACE_CULL_EN
  assign backface = area2[AW-1];
`else
  assign backface = 1'b0;
`endif

  assign reject_now = (area2 == '0) | (&x_low) | (&x_high) | (&y_low) | (&y_high)
                    | (&z_low) | backface;

  logic       draw_en_reg, draw_en_next;
  logic       in_draw_done_reg, in_draw_done_next;
  logic [1:0] cnt_inc;

  always_comb begin
    state_next        = state_reg;
    draw_en_next      = 1'b0;
    in_draw_done_next = 1'b0;
    cnt_inc           = 2'b00;
    case (state_reg)
      S_IDLE:   if (in_draw_en) state_next = S_EDGE;
      S_EDGE:   state_next = S_CROSS;
      S_CROSS:  state_next = S_DECIDE;
      S_DECIDE: begin
        if (reject_now) begin
          state_next        = S_REJECT;
          in_draw_done_next = 1'b1;
          cnt_inc[1]        = 1'b1;
        end else begin
          state_next   = S_ISSUE;
          draw_en_next = 1'b1;
        end
      end
      S_REJECT: state_next = S_IDLE;
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT: begin
        if (draw_done) begin
          state_next        = S_IDLE;
          in_draw_done_next = 1'b1;
          cnt_inc[0]        = 1'b1;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      draw_en_reg      <= 1'b0;
      in_draw_done_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      draw_en_reg      <= draw_en_next;
      in_draw_done_reg <= in_draw_done_next;
    end
  end

  assign draw_en      = draw_en_reg;
  assign in_draw_done = in_draw_done_reg;

  // Index 0 counts accepted triangles, index 1 rejected ones.
  logic [1:0][COUNT_WIDTH-1:0] cnt_val;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [COUNT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge clock) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + COUNT_WIDTH'(1);
      end
    end
    assign cnt_val[gi] = cnt_reg;
  end

  assign accepted_cnt = cnt_val[0];
  assign rejected_cnt = cnt_val[1];

endmodule

// File: tb/tb_triangle_cull_stage.sv
// Bench for triangle_cull_stage: directed table, hand-written corner sequences and
// random triangles checked against an arithmetic reference; a 3-bit-counter copy checks saturation.
module tb_triangle_cull_stage;

  localparam int W  = 32;
  localparam int CW = 3;
  localparam int NW = 3;

  typedef struct {
    int         c[9];
    logic [2:0] col;
    bit         acc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [8:0][W-1:0] in_c;
  logic [CW-1:0]     in_colour;
  logic              in_draw_en;
  logic              draw_done;

  logic [8:0][W-1:0] o_c;
  logic [CW-1:0]     o_colour;
  logic              o_draw_en, o_in_draw_done;
  logic [15:0]       o_acc, o_rej;

  logic [8:0][W-1:0] n_c;
  logic [CW-1:0]     n_colour;
  logic              n_draw_en, n_in_draw_done;
  logic [NW-1:0]     n_acc, n_rej;

  triangle_cull_stage dut (
    .clock(clock), .reset(reset),
    .in_ax(in_c[0]), .in_ay(in_c[1]), .in_az(in_c[2]),
    .in_bx(in_c[3]), .in_by(in_c[4]), .in_bz(in_c[5]),
    .in_cx(in_c[6]), .in_cy(in_c[7]), .in_cz(in_c[8]),
    .in_colour(in_colour), .in_draw_en(in_draw_en), .in_draw_done(o_in_draw_done),
    .ax(o_c[0]), .ay(o_c[1]), .az(o_c[2]),
    .bx(o_c[3]), .by(o_c[4]), .bz(o_c[5]),
    .cx(o_c[6]), .cy(o_c[7]), .cz(o_c[8]),
    .colour(o_colour), .draw_en(o_draw_en), .draw_done(draw_done),
    .accepted_cnt(o_acc), .rejected_cnt(o_rej)
  );

  triangle_cull_stage #(.COUNT_WIDTH(NW)) dut_narrow (
    .clock(clock), .reset(reset),
    .in_ax(in_c[0]), .in_ay(in_c[1]), .in_az(in_c[2]),
    .in_bx(in_c[3]), .in_by(in_c[4]), .in_bz(in_c[5]),
    .in_cx(in_c[6]), .in_cy(in_c[7]), .in_cz(in_c[8]),
    .in_colour(in_colour), .in_draw_en(in_draw_en), .in_draw_done(n_in_draw_done),
    .ax(n_c[0]), .ay(n_c[1]), .az(n_c[2]),
    .bx(n_c[3]), .by(n_c[4]), .bz(n_c[5]),
    .cx(n_c[6]), .cy(n_c[7]), .cz(n_c[8]),
    .colour(n_colour), .draw_en(n_draw_en), .draw_done(draw_done),
    .accepted_cnt(n_acc), .rejected_cnt(n_rej)
  );

  int n_checks = 0;
  int n_err    = 0;
  int exp_acc  = 0;
  int exp_rej  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input int ax_, input int ay_, input int az_,
                              input int bx_, input int by_, input int bz_,
                              input int cx_, input int cy_, input int cz_,
                              input logic [2:0] col, input bit acc);
    vec_t t;
    t.c[0] = ax_; t.c[1] = ay_; t.c[2] = az_;
    t.c[3] = bx_; t.c[4] = by_; t.c[5] = bz_;
    t.c[6] = cx_; t.c[7] = cy_; t.c[8] = cz_;
    t.col = col;
    t.acc = acc;
    return t;
  endfunction

  // Reference: twice the signed area with wide plain arithmetic, then the rejection rules.
  function automatic bit model_accept(input vec_t t);
    logic signed [127:0] x[3], y[3];
    logic signed [127:0] area;
    int nxl = 0, nxh = 0, nyl = 0, nyh = 0, nzl = 0;
    for (int i = 0; i < 3; i++) begin
      x[i] = t.c[3*i];
      y[i] = t.c[3*i+1];
      if (t.c[3*i]   < 0)   nxl++;
      if (t.c[3*i]   >= 320) nxh++;
      if (t.c[3*i+1] < 0)   nyl++;
      if (t.c[3*i+1] >= 240) nyh++;
      if (t.c[3*i+2] < 0)   nzl++;
    end
    area = (x[1] - x[0]) * (y[2] - y[0]) - (y[1] - y[0]) * (x[2] - x[0]);
    if (area == 0) return 1'b0;
    if (nxl == 3 || nxh == 3 || nyl == 3 || nyh == 3 || nzl == 3) return 1'b0;
`ifdef BACKFACE_CULL_EN
    if (area < 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic vec_t rand_tri();
    vec_t t;
    int   mode = int'($urandom_range(0, 3));
    int   dx   = int'($urandom_range(0, 40)) - 20;
    int   dy   = int'($urandom_range(0, 40)) - 20;
    int   k    = int'($urandom_range(2, 3));
    for (int i = 0; i < 3; i++) begin
      case (mode)
        0: begin
          t.c[3*i]   = int'($urandom_range(0, 500)) - 100;
          t.c[3*i+1] = int'($urandom_range(0, 400)) - 100;
          t.c[3*i+2] = int'($urandom_range(0, 30)) - 5;
        end
        1: begin
          t.c[3*i]   = int'($urandom);
          t.c[3*i+1] = int'($urandom);
          t.c[3*i+2] = int'($urandom);
        end
        2: begin
          t.c[3*i]   = int'($urandom_range(0, 200));
          t.c[3*i+1] = int'($urandom_range(0, 200));
          t.c[3*i+2] = int'($urandom_range(1, 9));
        end
        default: begin
          t.c[3*i]   = int'($urandom_range(300, 700));
          t.c[3*i+1] = int'($urandom_range(0, 239));
          t.c[3*i+2] = int'($urandom_range(0, 9));
        end
      endcase
    end
    if (mode == 2) begin
      t.c[3] = t.c[0] + dx;     t.c[4] = t.c[1] + dy;
      t.c[6] = t.c[0] + k * dx; t.c[7] = t.c[1] + k * dy;
    end
    t.col = 3'($urandom);
    t.acc = model_accept(t);
    return t;
  endfunction

  task automatic drive_tri(input vec_t t);
    for (int i = 0; i < 9; i++) in_c[i] = t.c[i];
    in_colour = t.col;
  endtask

  task automatic maybe_intr(input int cyc, input int intr, input vec_t alt);
    if (cyc == intr) begin
      drive_tri(alt);
      in_draw_en = 1'b1;
    end else begin
      in_draw_en = 1'b0;
    end
  endtask

  task automatic check_coords(input string tag, input vec_t t);
    logic [W-1:0] e;
    for (int i = 0; i < 9; i++) begin
      e = t.c[i];
      check($sformatf("%s coord%0d", tag, i), 64'(o_c[i]), 64'(e));
    end
    check({tag, " colour"}, 64'(o_colour), 64'(t.col));
  endtask

  task automatic check_counts(input string tag);
    int na = (exp_acc > 7) ? 7 : exp_acc;
    int nr = (exp_rej > 7) ? 7 : exp_rej;
    check({tag, " accepted_cnt"}, 64'(o_acc), 64'(exp_acc));
    check({tag, " rejected_cnt"}, 64'(o_rej), 64'(exp_rej));
    check({tag, " narrow accepted_cnt"}, 64'(n_acc), 64'(na));
    check({tag, " narrow rejected_cnt"}, 64'(n_rej), 64'(nr));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen |= o_draw_en | o_in_draw_done;
      step();
    end
    check({tag, " quiet"}, 64'(seen), 64'(0));
  endtask

  // One full transaction; cycle 0 is the in_draw_en cycle. intr pulses alt on
  // in_draw_en in that cycle (4 or later), which the DUT must ignore.
  task automatic run_tri(input string tag, input vec_t t, input int dd_cycle,
                         input int intr, input vec_t alt);
    drive_tri(t);
    in_draw_en = 1'b1;
    step();
    in_draw_en = 1'b0;
    drive_tri(alt);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      check($sformatf("%s early pulses c%0d", tag, cyc),
            64'({o_draw_en, o_in_draw_done}), 64'(0));
      step();
    end
    maybe_intr(4, intr, alt);
    check({tag, " draw_en@4"}, 64'(o_draw_en), 64'(t.acc));
    check({tag, " in_draw_done@4"}, 64'(o_in_draw_done), 64'(!t.acc));
    if (t.acc) begin
      check_coords({tag, " issue"}, t);
      step();
      for (int cyc = 5; cyc < dd_cycle; cyc++) begin
        maybe_intr(cyc, intr, alt);
        check($sformatf("%s wait pulses c%0d", tag, cyc),
              64'({o_draw_en, o_in_draw_done}), 64'(0));
        step();
      end
      maybe_intr(dd_cycle, intr, alt);
      check_coords({tag, " hold"}, t);
      draw_done = 1'b1;
      step();
      draw_done  = 1'b0;
      in_draw_en = 1'b0;
      exp_acc++;
      check({tag, " in_draw_done after draw_done"}, 64'(o_in_draw_done), 64'(1));
      step();
      check({tag, " single in_draw_done"}, 64'(o_in_draw_done), 64'(0));
      check_counts(tag);
    end else begin
      step();
      in_draw_en = 1'b0;
      exp_rej++;
      check({tag, " reject pulse width"}, 64'(o_in_draw_done), 64'(0));
      check_counts(tag);
    end
    $display("%s: coords a=(%0d,%0d,%0d) b=(%0d,%0d,%0d) c=(%0d,%0d,%0d) expect %s acc=%0d rej=%0d",
             tag, t.c[0], t.c[1], t.c[2], t.c[3], t.c[4], t.c[5], t.c[6], t.c[7], t.c[8],
             t.acc ? "accept" : "reject", o_acc, o_rej);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[14];
  vec_t s1, s1_swap, alt_t, far_t, rt;
  logic any_nz;

  initial begin
    in_c       = '0;
    in_colour  = '0;
    in_draw_en = 1'b0;
    draw_done  = 1'b0;

    s1      = mk(10, 10, 5, 100, 10, 5, 10, 100, 5, 3'b101, 1'b1);
`ifdef BACKFACE_CULL_EN
    s1_swap = mk(10, 10, 5, 10, 100, 5, 100, 10, 5, 3'b101, 1'b0);
`else
    s1_swap = mk(10, 10, 5, 10, 100, 5, 100, 10, 5, 3'b101, 1'b1);
`endif
    alt_t   = mk(1, 2, 3, 44, 55, 66, 7, 88, 9, 3'b010, 1'b1);
    far_t   = mk(400, 10, 1, 500, 10, 1, 400, 90, 1, 3'b001, 1'b0);

    tbl[0]  = s1;
    tbl[1]  = mk(0, 0, 1, 50, 50, 1, 100, 100, 1, 3'b011, 1'b0);
    tbl[2]  = far_t;
    tbl[3]  = mk(319, 10, 1, 500, 10, 1, 400, 90, 1, 3'b110, 1'b1);
    tbl[4]  = s1_swap;
    tbl[5]  = mk(-10, 10, 1, -1, 10, 1, -10, 100, 1, 3'b111, 1'b0);
    tbl[6]  = mk(10, 240, 1, 100, 240, 1, 10, 300, 1, 3'b100, 1'b0);
    tbl[7]  = mk(10, 239, 1, 100, 240, 1, 10, 300, 1, 3'b100, 1'b1);
    tbl[8]  = mk(10, -100, 1, 100, -100, 1, 10, -1, 1, 3'b010, 1'b0);
    tbl[9]  = mk(10, 10, -1, 100, 10, -1, 10, 100, -1, 3'b001, 1'b0);
    tbl[10] = mk(10, 10, 0, 100, 10, -1, 10, 100, -1, 3'b001, 1'b1);
    tbl[11] = mk(32'sh80000000, 32'sh80000000, 1, 32'sh7fffffff, 32'sh80000000, 1,
                 32'sh80000000, 32'sh7fffffff, 1, 3'b110, 1'b1);
    tbl[12] = mk(0, 0, 1, 319, 0, 1, 0, 239, 1, 3'b011, 1'b1);
    tbl[13] = mk(-1, -1, 1, 0, 0, 1, 0, 0, 1, 3'b101, 1'b0);

    repeat (3) step();
    any_nz = |o_c;
    check("reset coords", 64'(any_nz), 64'(0));
    check("reset colour", 64'(o_colour), 64'(0));
    check("reset pulses", 64'({o_draw_en, o_in_draw_done}), 64'(0));
    check_counts("reset");
    reset = 1'b1;
    step();

    run_tri("s1_accept", tbl[0], 9, 0, alt_t);
    run_tri("s2_collinear", tbl[1], 0, 0, alt_t);

    // Reset during WAIT: late draw_done must not produce in_draw_done.
    drive_tri(s1);
    in_draw_en = 1'b1;
    step();
    in_draw_en = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_acc = 0;
    exp_rej = 0;
    any_nz = |o_c;
    check("wait-reset coords", 64'(any_nz), 64'(0));
    check("wait-reset colour", 64'(o_colour), 64'(0));
    check("wait-reset pulses", 64'({o_draw_en, o_in_draw_done}), 64'(0));
    check_counts("wait-reset");
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    expect_quiet("post-reset draw_done", 5);
    check_counts("post-reset draw_done");
    $display("reset during WAIT: acc=%0d rej=%0d", o_acc, o_rej);

    for (int i = 0; i < 14; i++) begin
      run_tri($sformatf("table%0d", i), tbl[i], 5 + (i % 4), 0, alt_t);
    end

    run_tri("s5_intr_wait", s1, 9, 6, alt_t);
    run_tri("intr_on_done", s1, 7, 7, alt_t);
    expect_quiet("intr_on_done after", 6);
    run_tri("intr_on_reject", far_t, 0, 4, alt_t);
    expect_quiet("intr_on_reject after", 6);

    for (int i = 0; i < 40; i++) begin
      rt = rand_tri();
      run_tri($sformatf("rand%0d", i), rt, int'($urandom_range(5, 8)),
              ($urandom_range(0, 3) == 0) ? 6 : 0, rand_tri());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
